// File: rtl/digit_sprite_pkg.sv
// Shared types and default colours for the decimal digit sprite renderer.
package digit_sprite_pkg;

  typedef enum logic [1:0] {
    GC_BG   = 2'd0,
    GC_EDGE = 2'd1,
    GC_FILL = 2'd2
  } glyph_class_t;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  localparam int DEF_BG_COLOR   = 391;
  localparam int DEF_EDGE_COLOR = 430;
  localparam int DEF_FILL_COLOR = 428;

  // Glyph-local rectangle, inclusive bounds.
  typedef struct packed {
    logic [4:0] x0;
    logic [4:0] x1;
    logic [4:0] y0;
    logic [4:0] y1;
  } seg_box_t;

endpackage

// File: rtl/digit_glyph_rom.sv
// Combinational glyph ROM: seven-segment style digits; the outline of each lit
// segment is EDGE, its interior is FILL, and interior wins where segments overlap.
module digit_glyph_rom import digit_sprite_pkg::*; #(
  parameter int GLYPH_W = 32,
  parameter int GLYPH_H = 24
) (
  input  logic [3:0]                 digit_i,
  input  logic [$clog2(GLYPH_H)-1:0] row_i,
  input  logic [$clog2(GLYPH_W)-1:0] col_i,
  output glyph_class_t               cls_o
);

  // Segment order a,b,c,d,e,f,g in bits 0..6.
  function automatic logic [6:0] seg_mask(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic seg_box_t seg_box(input int s);
    case (s)
      0:       return '{x0: 5'd6,  x1: 5'd25, y0: 5'd2,  y1: 5'd5};
      1:       return '{x0: 5'd22, x1: 5'd25, y0: 5'd2,  y1: 5'd13};
      2:       return '{x0: 5'd22, x1: 5'd25, y0: 5'd10, y1: 5'd21};
      3:       return '{x0: 5'd6,  x1: 5'd25, y0: 5'd18, y1: 5'd21};
      4:       return '{x0: 5'd6,  x1: 5'd9,  y0: 5'd10, y1: 5'd21};
      5:       return '{x0: 5'd6,  x1: 5'd9,  y0: 5'd2,  y1: 5'd13};
      default: return '{x0: 5'd6,  x1: 5'd25, y0: 5'd10, y1: 5'd13};
    endcase
  endfunction

  function automatic glyph_class_t classify(input logic [3:0] d, input int r, input int c);
    logic [6:0] m;
    seg_box_t   b;
    logic       f;
    logic       e;
    m = seg_mask(d);
    f = 1'b0;
    e = 1'b0;
    for (int s = 0; s < 7; s++) begin
      b = seg_box(s);
      if (m[3'(s)] && c >= int'(b.x0) && c <= int'(b.x1) &&
          r >= int'(b.y0) && r <= int'(b.y1)) begin
        if (c > int'(b.x0) && c < int'(b.x1) && r > int'(b.y0) && r < int'(b.y1))
          f = 1'b1;
        else
          e = 1'b1;
      end
    end
    if (f) return GC_FILL;
    if (e) return GC_EDGE;
    return GC_BG;
  endfunction

  assign cls_o = classify(digit_i, int'(row_i), int'(col_i));

endmodule

// File: rtl/digit_sprite_renderer.sv
// Renders an unsigned value as NUM_DIGITS decimal glyphs; value is latched per frame and
// converted by double-dabble. Optional macro DIGIT_LEADING_ZERO_BLANK_EN blanks leading zeros.
module digit_sprite_renderer import digit_sprite_pkg::*; #(
  parameter int NUM_DIGITS = 3,
  parameter int VAL_W      = 10,
  parameter int GLYPH_W    = 32,
  parameter int GLYPH_H    = 24,
  parameter int COLOR_W    = 9,
  parameter int BG_COLOR   = DEF_BG_COLOR,
  parameter int EDGE_COLOR = DEF_EDGE_COLOR,
  parameter int FILL_COLOR = DEF_FILL_COLOR
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic [VAL_W-1:0]   value,
  input  logic [9:0]         origin_x,
  input  logic [9:0]         origin_y,
  input  logic [9:0]         draw_x,
  input  logic [9:0]         draw_y,
  input  logic               draw_en,
  output logic               pix_valid,
  output logic               pix_hit,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               overflow
);

  localparam int COL_W = $clog2(GLYPH_W);
  localparam int ROW_W = $clog2(GLYPH_H);
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int unsigned LIMIT = 10 ** NUM_DIGITS;

  // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin} left.
  function automatic logic [BCD_W+VAL_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                     input logic [VAL_W-1:0] bin);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

  conv_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             overflow_q, overflow_d;
  bcd_t             digits_q [NUM_DIGITS];
  bcd_t             digits_d [NUM_DIGITS];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= digits_d[i];
    end
  end

  // Conversion scratch needs no reset: it is reloaded before every use.
  always_ff @(posedge Clk) begin
    bin_q      <= bin_d;
    bcd_q      <= bcd_d;
    ovf_pend_q <= ovf_pend_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_pend_d = ovf_pend_q;
    overflow_d = overflow_q;
    for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = digits_q[i];
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          bin_d      = value;
          bcd_d      = '0;
          cnt_d      = CNT_W'(VAL_W);
          ovf_pend_d = (32'(value) >= LIMIT);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = dd_step(bcd_q, bin_q);
        cnt_d          = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        for (int i = 0; i < NUM_DIGITS; i++)
          digits_d[i] = ovf_pend_q ? 4'd9 : bcd_q[BCD_W-1-4*i -: 4];
        overflow_d = ovf_pend_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign overflow = overflow_q;

  // ---- stage 1: field-relative coordinates ----
  logic [10:0]      dx, dy;
  logic             vld_p1_q, inside_p1_q;
  logic [DIG_W-1:0] idx_p1_q;
  logic [COL_W-1:0] col_p1_q;
  logic [ROW_W-1:0] row_p1_q;

  assign dx = {1'b0, draw_x} - {1'b0, origin_x};
  assign dy = {1'b0, draw_y} - {1'b0, origin_y};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p1_q    <= 1'b0;
      inside_p1_q <= 1'b0;
    end else begin
      vld_p1_q    <= draw_en;
      inside_p1_q <= (dx < 11'(NUM_DIGITS * GLYPH_W)) && (dy < 11'(GLYPH_H));
    end
  end

  always_ff @(posedge Clk) begin
    idx_p1_q <= DIG_W'(dx >> COL_W);
    col_p1_q <= dx[COL_W-1:0];
    row_p1_q <= dy[ROW_W-1:0];
  end

  // ---- stage 2: glyph lookup and colour ----
  bcd_t               digit_sel;
  logic               blank;
  glyph_class_t       cls;
  logic               vld_p2_q, hit_p2_q, hit_p2_d;
  logic [COLOR_W-1:0] color_p2_q, color_p2_d;
`ifdef DIGIT_LEADING_ZERO_BLANK_EN
  logic               lead;
`endif

  always_comb begin
    digit_sel = '0;
    blank     = 1'b0;
`ifdef DIGIT_LEADING_ZERO_BLANK_EN
    lead      = 1'b1;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef DIGIT_LEADING_ZERO_BLANK_EN
      lead = lead && (digits_q[i] == 4'd0);
`endif
      if (idx_p1_q == DIG_W'(i)) begin
        digit_sel = digits_q[i];
`ifdef DIGIT_LEADING_ZERO_BLANK_EN
        blank = lead && (i != NUM_DIGITS - 1);
`endif
      end
    end
  end

  digit_glyph_rom #(
    .GLYPH_W(GLYPH_W),
    .GLYPH_H(GLYPH_H)
  ) u_rom (
    .digit_i(digit_sel),
    .row_i  (row_p1_q),
    .col_i  (col_p1_q),
    .cls_o  (cls)
  );

  always_comb begin
    color_p2_d = COLOR_W'(BG_COLOR);
    hit_p2_d   = 1'b0;
    if (inside_p1_q && !blank) begin
      case (cls)
        GC_EDGE: begin
          color_p2_d = COLOR_W'(EDGE_COLOR);
          hit_p2_d   = 1'b1;
        end
        GC_FILL: begin
          color_p2_d = COLOR_W'(FILL_COLOR);
          hit_p2_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p2_q   <= 1'b0;
      hit_p2_q   <= 1'b0;
      color_p2_q <= COLOR_W'(BG_COLOR);
    end else begin
      vld_p2_q   <= vld_p1_q;
      hit_p2_q   <= hit_p2_d;
      color_p2_q <= color_p2_d;
    end
  end

  assign pix_valid = vld_p2_q;
  assign pix_hit   = hit_p2_q;
  assign pix_color = color_p2_q;

endmodule

// File: tb/tb_digit_sprite_renderer.sv
// Directed bench for digit_sprite_renderer: glyph pixels checked against hand-derived classes.
module tb_digit_sprite_renderer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_start;
  logic [9:0] value;
  logic [9:0] origin_x, origin_y, draw_x, draw_y;
  logic       draw_en;
  logic       pix_valid, pix_hit, busy, overflow;
  logic [8:0] pix_color;

  int total = 0;
  int bad   = 0;

  digit_sprite_renderer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .value      (value),
    .origin_x   (origin_x),
    .origin_y   (origin_y),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_en    (draw_en),
    .pix_valid  (pix_valid),
    .pix_hit    (pix_hit),
    .pix_color  (pix_color),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hit;
    logic [8:0] col;
  } vec_t;

  vec_t tab_a [12];
  vec_t tab_b [6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_pix(input string nm, input int x, input int y, input int hit, input int col);
    @(negedge Clk);
    draw_x  = 10'(x);
    draw_y  = 10'(y);
    draw_en = 1'b1;
    @(negedge Clk);
    draw_en = 1'b0;
    @(posedge Clk);
    #1;
    chk({nm, ".valid"}, int'(pix_valid), 1);
    chk({nm, ".hit"}, int'(pix_hit), hit);
    chk({nm, ".color"}, int'(pix_color), col);
  endtask

  // Pulse frame_start with v; return how many post-edge samples saw busy high.
  task automatic run_conv(input int v, output int cyc);
    @(negedge Clk);
    value       = 10'(v);
    frame_start = 1'b1;
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    cyc = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      cyc++;
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    int cyc;
    Reset = 1'b1; frame_start = 1'b0; value = '0; draw_en = 1'b0;
    origin_x = 10'd100; origin_y = 10'd50; draw_x = '0; draw_y = '0;

    // value 209 -> slots '2','0','9'; glyph columns 6..25, rows 2..21
    tab_a[0]  = '{x: 10'd123, y: 10'd66, hit: 1'b0, col: 9'd391};
    tab_a[1]  = '{x: 10'd115, y: 10'd61, hit: 1'b1, col: 9'd428};
    tab_a[2]  = '{x: 10'd147, y: 10'd53, hit: 1'b1, col: 9'd428};
    tab_a[3]  = '{x: 10'd147, y: 10'd61, hit: 1'b0, col: 9'd391};
    tab_a[4]  = '{x: 10'd139, y: 10'd65, hit: 1'b1, col: 9'd428};
    tab_a[5]  = '{x: 10'd138, y: 10'd53, hit: 1'b1, col: 9'd430};
    tab_a[6]  = '{x: 10'd171, y: 10'd65, hit: 1'b0, col: 9'd391};
    tab_a[7]  = '{x: 10'd187, y: 10'd66, hit: 1'b1, col: 9'd428};
    tab_a[8]  = '{x: 10'd179, y: 10'd68, hit: 1'b1, col: 9'd430};
    tab_a[9]  = '{x: 10'd99,  y: 10'd61, hit: 1'b0, col: 9'd391};
    tab_a[10] = '{x: 10'd196, y: 10'd53, hit: 1'b0, col: 9'd391};
    tab_a[11] = '{x: 10'd147, y: 10'd74, hit: 1'b0, col: 9'd391};
    // value 1000 -> '9' in every slot: e-segment off, g-segment on
    tab_b[0]  = '{x: 10'd107, y: 10'd65, hit: 1'b0, col: 9'd391};
    tab_b[1]  = '{x: 10'd115, y: 10'd61, hit: 1'b1, col: 9'd428};
    tab_b[2]  = '{x: 10'd139, y: 10'd65, hit: 1'b0, col: 9'd391};
    tab_b[3]  = '{x: 10'd147, y: 10'd61, hit: 1'b1, col: 9'd428};
    tab_b[4]  = '{x: 10'd171, y: 10'd65, hit: 1'b0, col: 9'd391};
    tab_b[5]  = '{x: 10'd187, y: 10'd66, hit: 1'b1, col: 9'd428};

    repeat (3) @(negedge Clk);
    chk("rst.valid", int'(pix_valid), 0);
    chk("rst.hit", int'(pix_hit), 0);
    chk("rst.color", int'(pix_color), 391);
    chk("rst.busy", int'(busy), 0);
    chk("rst.overflow", int'(overflow), 0);
    @(negedge Clk);
    Reset = 1'b0;

    // pix_valid tracks draw_en with two cycles of latency
    @(negedge Clk);
    draw_x = 10'd99; draw_y = 10'd61; draw_en = 1'b1;
    @(negedge Clk);
    draw_en = 1'b0;
    chk("lat.e1", int'(pix_valid), 0);
    @(posedge Clk); #1;
    chk("lat.e2", int'(pix_valid), 1);
    @(posedge Clk); #1;
    chk("lat.e3", int'(pix_valid), 0);

    run_conv(209, cyc);
    chk("conv209.busy_cycles", cyc, 11);
    chk("conv209.overflow", int'(overflow), 0);
    for (int i = 0; i < 12; i++)
      check_pix($sformatf("v209[%0d]", i), int'(tab_a[i].x), int'(tab_a[i].y),
                int'(tab_a[i].hit), int'(tab_a[i].col));

    // Reset in the middle of SHIFT
    @(negedge Clk);
    value = 10'd555; frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    repeat (2) @(negedge Clk);
    chk("midrst.busy_before", int'(busy), 1);
    Reset = 1'b1;
    draw_x = 10'd139; draw_y = 10'd65; draw_en = 1'b1;
    #1;
    chk("midrst.busy", int'(busy), 0);
    repeat (2) @(negedge Clk);
    chk("midrst.valid", int'(pix_valid), 0);
    chk("midrst.color", int'(pix_color), 391);
    chk("midrst.hit", int'(pix_hit), 0);
    Reset = 1'b0; draw_en = 1'b0;
    chk("midrst.overflow", int'(overflow), 0);
    check_pix("midrst.slot0", 115, 61, 0, 391);
    check_pix("midrst.slot2", 179, 53, 1, 428);
    @(posedge Clk); #1;
    chk("midrst.idle", int'(busy), 0);

    run_conv(1000, cyc);
    chk("conv1000.busy_cycles", cyc, 11);
    chk("conv1000.overflow", int'(overflow), 1);
    for (int i = 0; i < 6; i++)
      check_pix($sformatf("v1000[%0d]", i), int'(tab_b[i].x), int'(tab_b[i].y),
                int'(tab_b[i].hit), int'(tab_b[i].col));

    // Second frame_start three cycles into a conversion is dropped
    @(negedge Clk);
    value = 10'd345; frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    value = 10'd678; frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    cyc = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      cyc++;
      @(posedge Clk); #1;
    end
    chk("repulse.remaining", cyc, 8);
    @(posedge Clk); #1;
    chk("repulse.no_restart", int'(busy), 0);
    chk("repulse.overflow", int'(overflow), 0);
    check_pix("v345.s0_e", 107, 65, 0, 391);
    check_pix("v345.s0_g", 115, 61, 1, 428);
    check_pix("v345.s1_a", 147, 53, 0, 391);
    check_pix("v345.s1_b", 155, 56, 1, 428);
    check_pix("v345.s2_b", 187, 56, 0, 391);
    check_pix("v345.s2_a", 179, 53, 1, 428);

    run_conv(7, cyc);
    chk("conv7.busy_cycles", cyc, 11);
`ifdef DIGIT_LEADING_ZERO_BLANK_EN
    check_pix("v7.s0_blank", 115, 53, 0, 391);
    check_pix("v7.s1_blank", 147, 53, 0, 391);
`else
    check_pix("v7.s0_zero", 115, 53, 1, 428);
    check_pix("v7.s1_zero", 147, 53, 1, 428);
`endif
    check_pix("v7.s2_a", 179, 53, 1, 428);
    check_pix("v7.s2_g", 179, 61, 0, 391);

    run_conv(0, cyc);
`ifdef DIGIT_LEADING_ZERO_BLANK_EN
    check_pix("v0.s1_blank", 147, 53, 0, 391);
`else
    check_pix("v0.s1_zero", 147, 53, 1, 428);
`endif
    check_pix("v0.s2_a", 179, 53, 1, 428);
    check_pix("v0.s2_g", 179, 61, 0, 391);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
